// File: rtl/layer_lut_writer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_lut_writer
//  Description : Loads a neuron lookup table from a stream of packed config
//                words, then serves one registered lookup per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_lut_writer #(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 2,
  parameter int CFG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 cfg_valid,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  output logic                 cfg_ready,
  output logic                 loaded,
  input  logic                 in_valid,
  input  logic [IN_BITS-1:0]   in_data,
  output logic                 out_valid,
  output logic [OUT_BITS-1:0]  out_data,
  output logic                 query_drop
);

  // Entries per load word, words per table, and the address split widths.
  // The table holds 2^IN_BITS entries stored as c_WORDS rows of one load
  // word each; an address selects a row by its upper bits and an entry
  // within the row by its lower bits.
  localparam int c_ENTRIES = CFG_WIDTH / OUT_BITS;
  localparam int c_WORDS   = (2 ** IN_BITS) / c_ENTRIES;
  localparam int c_EBITS   = $clog2(c_ENTRIES);
  localparam int c_CBITS   = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_ARMED = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [c_CBITS-1:0]   r_cnt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_armed;
  logic [CFG_WIDTH-1:0] r_mem [c_WORDS];
  logic [CFG_WIDTH-1:0] w_rword;
  logic [OUT_BITS-1:0]  w_entry;

  // A load_start pulse takes priority, so a beat in the same cycle is ignored.
  assign w_accept = (r_state == c_LOAD) && cfg_valid && !load_start;
  assign w_last   = w_accept && (r_cnt == c_CBITS'(c_WORDS - 1));
  assign w_armed  = (r_state == c_ARMED);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: load_start (re)enters LOAD from any state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (load_start) w_next = c_LOAD;
      c_LOAD:  if (load_start) w_next = c_LOAD;
               else if (w_last) w_next = c_ARMED;
      c_ARMED: if (load_start) w_next = c_LOAD;
      default: w_next = c_IDLE;
    endcase
  end

  // State-decoded outputs; both drop as soon as reset forces IDLE.
  always_comb begin
    cfg_ready = (r_state == c_LOAD);
    loaded    = (r_state == c_ARMED);
  end

  // Word counter: cleared on load_start, returns to 0 on the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_cnt <= '0;
    else if (load_start) r_cnt <= '0;
    else if (w_last)     r_cnt <= '0;
    else if (w_accept)   r_cnt <= r_cnt + 1'b1;
  end

  // Table storage, written one packed word per accepted beat; no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_cnt] <= cfg_data;
  end

  assign w_rword = r_mem[in_data[IN_BITS-1:c_EBITS]];

  generate
    if (c_ENTRIES > 1) begin : g_sel_multi
      logic [c_EBITS-1:0] w_eidx;
      assign w_eidx  = in_data[c_EBITS-1:0];
      assign w_entry = w_rword[int'(w_eidx) * OUT_BITS +: OUT_BITS];
    end else begin : g_sel_single
      assign w_entry = w_rword;
    end
  endgenerate

  // Registered lookup result; out_data holds when nothing is served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      query_drop <= 1'b0;
    end else begin
      out_valid  <= in_valid && w_armed;
      query_drop <= in_valid && !w_armed;
      if (in_valid && w_armed) out_data <= w_entry;
    end
  end

endmodule
`default_nettype wire
